// File: rtl/controlador_comportas_pkg.sv
// controlador_comportas_pkg: shared definitions for the multi-gate controller.
// Holds the command byte layout, opcode values, gate state encoding and the
// duty-cycle helper used by every gate channel.
package controlador_comportas_pkg;

  localparam int OPCODE_MSB = 7;
  localparam int OPCODE_LSB = 6;
  localparam int CANAL_MSB  = 5;
  localparam int CANAL_LSB  = 0;
  localparam int CANAL_W    = CANAL_MSB - CANAL_LSB + 1;

  typedef enum logic [1:0] {
    OP_ABRIR_TEMP   = 2'b00,
    OP_FECHAR       = 2'b01,
    OP_ABRIR_MANTER = 2'b10,
    OP_RESERVADO    = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    FECHADA  = 2'b00,
    ABRINDO  = 2'b01,
    ABERTA   = 2'b10,
    FECHANDO = 2'b11
  } estado_t;

  // High time of the servo pulse for a given gate position.
  function automatic int calcDuty(input int posicao, input int pwmMin, input int pwmPasso);
    return pwmMin + posicao * pwmPasso;
  endfunction

endpackage

// File: rtl/canal_comporta.sv
// canal_comporta: one gate of the controller.
// Runs the FECHADA/ABRINDO/ABERTA/FECHANDO sequencer with a stepped position
// ramp, the hold timer and manter flag, and produces the gate's servo pulse
// from the shared PWM counter.
// Optional feature macro: COMPORTAS_REABRIR_EN lets an open command reverse a
// closing gate; without it only abrirExterno can reverse a closing gate.
module canal_comporta
  import controlador_comportas_pkg::*;
#(
  parameter int POS_BITS      = 4,
  parameter int CICLOS_PASSO  = 50000,
  parameter int CICLOS_ABERTA = 1000000,
  parameter int PWM_MIN       = 50000,
  parameter int PWM_PASSO     = 3333,
  parameter int CONT_W        = 20,
  parameter int DUTY_W        = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmdAbrir,
  input  logic              cmdManter,
  input  logic              cmdFechar,
  input  logic              abrirExterno,
  input  logic              pwmWrap,
  input  logic [CONT_W-1:0] pwmContador,
  output logic              pwm,
  output logic              aberta,
  output logic              ocupado
);

  localparam int PASSO_W  = (CICLOS_PASSO > 1) ? $clog2(CICLOS_PASSO) : 1;
  localparam int ABERTA_W = (CICLOS_ABERTA > 1) ? $clog2(CICLOS_ABERTA) : 1;
  localparam logic [POS_BITS-1:0] POS_MAX    = '1;
  localparam logic [PASSO_W-1:0]  PASSO_FIM  = PASSO_W'(CICLOS_PASSO - 1);
  localparam logic [ABERTA_W-1:0] ABERTA_FIM = ABERTA_W'(CICLOS_ABERTA - 1);
  localparam logic [DUTY_W-1:0]   DUTY_MIN   = DUTY_W'(PWM_MIN);

  estado_t             estado;
  logic [POS_BITS-1:0] pos;
  logic [PASSO_W-1:0]  stepTimer;
  logic [ABERTA_W-1:0] holdTimer;
  logic                manter;
  logic [DUTY_W-1:0]   duty;
  logic                reabrirCmd;

`ifdef COMPORTAS_REABRIR_EN
  assign reabrirCmd = cmdAbrir;
`else
  assign reabrirCmd = 1'b0;
`endif

  assign aberta  = (estado == ABERTA);
  assign ocupado = (estado != FECHADA);

  // Gate sequencer: state, position ramp, step/hold timers and manter flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= FECHADA;
      pos       <= '0;
      stepTimer <= '0;
      holdTimer <= '0;
      manter    <= 1'b0;
    end else begin
      case (estado)
        FECHADA: begin
          if (cmdAbrir || abrirExterno) begin
            estado    <= ABRINDO;
            manter    <= cmdManter;
            stepTimer <= '0;
            holdTimer <= '0;
          end
        end
        ABRINDO: begin
          if (cmdFechar && !abrirExterno) begin
            estado    <= FECHANDO;
            manter    <= 1'b0;
            stepTimer <= '0;
            holdTimer <= '0;
          end else begin
            if (cmdManter) manter <= 1'b1;
            if (pos == POS_MAX) begin
              estado    <= ABERTA;
              stepTimer <= '0;
              holdTimer <= '0;
            end else if (stepTimer == PASSO_FIM) begin
              pos       <= pos + POS_BITS'(1);
              stepTimer <= '0;
              if (pos == POS_MAX - POS_BITS'(1)) begin
                estado    <= ABERTA;
                holdTimer <= '0;
              end
            end else begin
              stepTimer <= stepTimer + PASSO_W'(1);
            end
          end
        end
        ABERTA: begin
          if (cmdFechar && !abrirExterno) begin
            estado    <= FECHANDO;
            manter    <= 1'b0;
            stepTimer <= '0;
            holdTimer <= '0;
          end else if (cmdAbrir) begin
            holdTimer <= '0;
            if (cmdManter) manter <= 1'b1;
          end else if (!abrirExterno && !manter) begin
            if (holdTimer == ABERTA_FIM) begin
              estado    <= FECHANDO;
              stepTimer <= '0;
              holdTimer <= '0;
            end else begin
              holdTimer <= holdTimer + ABERTA_W'(1);
            end
          end
        end
        FECHANDO: begin
          if (abrirExterno || reabrirCmd) begin
            estado    <= ABRINDO;
            stepTimer <= '0;
            holdTimer <= '0;
            if (reabrirCmd && cmdManter) manter <= 1'b1;
          end else if (pos == '0) begin
            estado    <= FECHADA;
            manter    <= 1'b0;
            stepTimer <= '0;
            holdTimer <= '0;
          end else if (stepTimer == PASSO_FIM) begin
            pos       <= pos - POS_BITS'(1);
            stepTimer <= '0;
            if (pos == POS_BITS'(1)) begin
              estado    <= FECHADA;
              manter    <= 1'b0;
              holdTimer <= '0;
            end
          end else begin
            stepTimer <= stepTimer + PASSO_W'(1);
          end
        end
        default: estado <= FECHADA;
      endcase
    end
  end

  // Duty is only refreshed at the period wrap so a pulse is never cut mid-period.
  always_ff @(posedge clock) begin
    if (reset) begin
      duty <= DUTY_MIN;
      pwm  <= 1'b0;
    end else begin
      if (pwmWrap) duty <= DUTY_W'(calcDuty(int'(pos), PWM_MIN, PWM_PASSO));
      pwm <= (DUTY_W'(pwmContador) < duty);
    end
  end

endmodule

// File: rtl/controlador_comportas.sv
// controlador_comportas: top of the multi-gate servo controller.
// Registers the UART command byte, decodes opcode/channel, flags rejected
// commands on erro_cmd, runs the shared PWM period counter and instantiates
// one canal_comporta per gate.
// Optional feature macro: COMPORTAS_REABRIR_EN (handled inside canal_comporta).
module controlador_comportas
  import controlador_comportas_pkg::*;
#(
  parameter int N_CANAIS      = 4,
  parameter int POS_BITS      = 4,
  parameter int CICLOS_PASSO  = 50000,
  parameter int CICLOS_ABERTA = 1000000,
  parameter int PWM_PERIODO   = 1000000,
  parameter int PWM_MIN       = 50000,
  parameter int PWM_PASSO     = 3333
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          rx_dado,
  input  logic                rx_valido,
  input  logic [N_CANAIS-1:0] abrir_externo,
  output logic [N_CANAIS-1:0] pwm,
  output logic [N_CANAIS-1:0] aberta,
  output logic [N_CANAIS-1:0] ocupado,
  output logic                erro_cmd
);

  localparam int CONT_W = (PWM_PERIODO > 1) ? $clog2(PWM_PERIODO) : 1;
  localparam int DUTY_W = $clog2(PWM_PERIODO + 1);
  localparam logic [CONT_W-1:0] CONT_FIM = CONT_W'(PWM_PERIODO - 1);

  logic [7:0]         rxDadoQ;
  logic               rxValidoQ;
  opcode_t            opcode;
  logic [CANAL_W-1:0] canal;
  logic               canalOk;
  logic               cmdErro;
  logic               cmdValido;
  logic [CONT_W-1:0]  pwmContador;
  logic               pwmWrap;

  assign opcode    = opcode_t'(rxDadoQ[OPCODE_MSB:OPCODE_LSB]);
  assign canal     = rxDadoQ[CANAL_MSB:CANAL_LSB];
  assign canalOk   = (32'(canal) < 32'(N_CANAIS));
  assign cmdErro   = rxValidoQ && ((opcode == OP_RESERVADO) || !canalOk);
  assign cmdValido = rxValidoQ && !cmdErro;
  assign pwmWrap   = (pwmContador == CONT_FIM);

  // Command capture stage; the gates act on the captured byte one edge later.
  always_ff @(posedge clock) begin
    if (reset) begin
      rxDadoQ   <= '0;
      rxValidoQ <= 1'b0;
      erro_cmd  <= 1'b0;
    end else begin
      rxDadoQ   <= rx_dado;
      rxValidoQ <= rx_valido;
      erro_cmd  <= cmdErro;
    end
  end

  // Shared PWM period counter, 0 .. PWM_PERIODO-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwmContador <= '0;
    end else if (pwmWrap) begin
      pwmContador <= '0;
    end else begin
      pwmContador <= pwmContador + CONT_W'(1);
    end
  end

  for (genvar i = 0; i < N_CANAIS; i++) begin : gCanal
    logic sel;
    assign sel = cmdValido && (canal == CANAL_W'(i));

    canal_comporta #(
      .POS_BITS      (POS_BITS),
      .CICLOS_PASSO  (CICLOS_PASSO),
      .CICLOS_ABERTA (CICLOS_ABERTA),
      .PWM_MIN       (PWM_MIN),
      .PWM_PASSO     (PWM_PASSO),
      .CONT_W        (CONT_W),
      .DUTY_W        (DUTY_W)
    ) uCanal (
      .clock        (clock),
      .reset        (reset),
      .cmdAbrir     (sel && ((opcode == OP_ABRIR_TEMP) || (opcode == OP_ABRIR_MANTER))),
      .cmdManter    (sel && (opcode == OP_ABRIR_MANTER)),
      .cmdFechar    (sel && (opcode == OP_FECHAR)),
      .abrirExterno (abrir_externo[i]),
      .pwmWrap      (pwmWrap),
      .pwmContador  (pwmContador),
      .pwm          (pwm[i]),
      .aberta       (aberta[i]),
      .ocupado      (ocupado[i])
    );
  end

endmodule

// File: tb/tb_controlador_comportas.sv
// tb_controlador_comportas: self-checking bench for controlador_comportas.
// A behavioural model of the gates (phases, tick counts, duty arithmetic)
// predicts every output each cycle; directed steps add timing checks.
// Honours COMPORTAS_REABRIR_EN when the bundle is built with it.
module tb_controlador_comportas;

  localparam int N    = 4;
  localparam int PB   = 2;
  localparam int CP   = 4;
  localparam int CA   = 10;
  localparam int PER  = 20;
  localparam int PMIN = 4;
  localparam int PP   = 2;
  localparam int PMAX = (1 << PB) - 1;
`ifdef COMPORTAS_REABRIR_EN
  localparam bit REABRIR = 1'b1;
`else
  localparam bit REABRIR = 1'b0;
`endif
  localparam int SHUT = 0, RISING = 1, OPEN = 2, FALLING = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   rx_dado;
  logic         rx_valido;
  logic [N-1:0] abrir_externo;
  logic [N-1:0] pwm, aberta, ocupado;
  logic         erro_cmd;

  int total = 0;
  int bad   = 0;

  int   ph[N], ps[N], tk[N], dutyM[N];
  bit   mt[N], pwmM[N];
  int   cnt;
  bit   erroM, pendValid;
  logic [7:0] pendByte;

  controlador_comportas #(
    .N_CANAIS(N), .POS_BITS(PB), .CICLOS_PASSO(CP), .CICLOS_ABERTA(CA),
    .PWM_PERIODO(PER), .PWM_MIN(PMIN), .PWM_PASSO(PP)
  ) dut (
    .clock(clock), .reset(reset), .rx_dado(rx_dado), .rx_valido(rx_valido),
    .abrir_externo(abrir_externo), .pwm(pwm), .aberta(aberta),
    .ocupado(ocupado), .erro_cmd(erro_cmd)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] dado, input logic valido);
    rx_dado   = dado;
    rx_valido = valido;
  endtask

  // One gate, one clock edge, written from the gate's behavioural rules.
  task automatic gateRule(input int g, input bit opn, input bit hold, input bit cls, input bit ext);
    case (ph[g])
      SHUT: if (opn || ext) begin ph[g] = RISING; tk[g] = 0; mt[g] = hold; end
      RISING: begin
        if (cls && !ext) begin ph[g] = FALLING; tk[g] = 0; mt[g] = 0; end
        else begin
          if (hold) mt[g] = 1;
          if (ps[g] == PMAX) begin ph[g] = OPEN; tk[g] = 0; end
          else begin
            tk[g]++;
            if (tk[g] == CP) begin
              ps[g]++; tk[g] = 0;
              if (ps[g] == PMAX) ph[g] = OPEN;
            end
          end
        end
      end
      OPEN: begin
        if (cls && !ext) begin ph[g] = FALLING; tk[g] = 0; mt[g] = 0; end
        else if (opn) begin tk[g] = 0; if (hold) mt[g] = 1; end
        else if (!ext && !mt[g]) begin
          tk[g]++;
          if (tk[g] == CA) begin ph[g] = FALLING; tk[g] = 0; end
        end
      end
      default: begin
        if (ext || (REABRIR && opn)) begin
          ph[g] = RISING; tk[g] = 0;
          if (REABRIR && hold) mt[g] = 1;
        end else if (ps[g] == 0) begin ph[g] = SHUT; mt[g] = 0; tk[g] = 0; end
        else begin
          tk[g]++;
          if (tk[g] == CP) begin
            ps[g]--; tk[g] = 0;
            if (ps[g] == 0) begin ph[g] = SHUT; mt[g] = 0; end
          end
        end
      end
    endcase
  endtask

  task automatic modelEdge();
    int op, ch;
    bit err, sel;
    if (reset) begin
      for (int g = 0; g < N; g++) begin
        ph[g] = SHUT; ps[g] = 0; tk[g] = 0; mt[g] = 0; dutyM[g] = PMIN; pwmM[g] = 0;
      end
      cnt = 0; erroM = 0; pendValid = 0; pendByte = 8'h00;
      return;
    end
    op  = int'(pendByte) / 64;
    ch  = int'(pendByte) % 64;
    err = pendValid && (op == 3 || ch >= N);
    for (int g = 0; g < N; g++) begin
      pwmM[g] = (cnt < dutyM[g]);
      if (cnt == PER - 1) dutyM[g] = PMIN + ps[g] * PP;
      sel = pendValid && !err && (ch == g);
      gateRule(g, sel && (op == 0 || op == 2), sel && (op == 2), sel && (op == 1), abrir_externo[g]);
    end
    cnt       = (cnt + 1) % PER;
    erroM     = err;
    pendValid = rx_valido;
    pendByte  = rx_dado;
  endtask

  task automatic step();
    logic [N-1:0] expAb, expOc, expPwm;
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    for (int g = 0; g < N; g++) begin
      expAb[g]  = (ph[g] == OPEN);
      expOc[g]  = (ph[g] != SHUT);
      expPwm[g] = pwmM[g];
    end
    checkOutput("aberta", 64'(aberta), 64'(expAb));
    checkOutput("ocupado", 64'(ocupado), 64'(expOc));
    checkOutput("pwm", 64'(pwm), 64'(expPwm));
    checkOutput("erro_cmd", 64'(erro_cmd), 64'(erroM));
  endtask

  task automatic sendCmd(input logic [7:0] b);
    applyStimulus(b, 1'b1);
    step();
    applyStimulus(8'h00, 1'b0);
    step();
  endtask

  initial begin
    int n;
    int hi[N];
    int idx;

    reset = 1'b1;
    abrir_externo = '0;
    applyStimulus(8'h00, 1'b0);
    repeat (3) step();
    checkOutput("resetAberta", 64'(aberta), 64'd0);
    checkOutput("resetOcupado", 64'(ocupado), 64'd0);
    checkOutput("resetPwm", 64'(pwm), 64'd0);
    checkOutput("resetErro", 64'(erro_cmd), 64'd0);
    reset = 1'b0;

    // Idle PWM: every gate high PWM_MIN cycles per period.
    for (int g = 0; g < N; g++) hi[g] = 0;
    repeat (PER) begin
      step();
      for (int g = 0; g < N; g++) hi[g] += int'(pwm[g]);
    end
    for (int g = 0; g < N; g++) checkOutput($sformatf("idlePwmHigh%0d", g), 64'(hi[g]), 64'd4);

    // Timed open of gate 1.
    $display("[TB] timed open gate 1");
    sendCmd(8'h01);
    checkOutput("ocupado1AtT1", 64'(ocupado[1]), 64'd1);
    n = 0;
    while (aberta[1] !== 1'b1 && n < 40) begin step(); n++; end
    checkOutput("abre1Ciclos", 64'(n), 64'd12);
    n = 0;
    while (aberta[1] === 1'b1 && n < 40) begin step(); n++; end
    checkOutput("hold1Ciclos", 64'(n), 64'd10);
    n = 0;
    while (ocupado[1] === 1'b1 && n < 40) begin step(); n++; end
    checkOutput("fecha1Ciclos", 64'(n), 64'd12);

    // Held open of gate 2, then explicit close.
    $display("[TB] held open gate 2");
    sendCmd(8'h82);
    repeat (110) step();
    checkOutput("aberta2Mantida", 64'(aberta[2]), 64'd1);
    hi[2] = 0;
    repeat (PER) begin step(); hi[2] += int'(pwm[2]); end
    checkOutput("pwm2HighAberta", 64'(hi[2]), 64'd10);
    sendCmd(8'h42);
    n = 0;
    while (ocupado[2] === 1'b1 && n < 40) begin step(); n++; end
    checkOutput("fecha2Ciclos", 64'(n), 64'd12);

    // Rejected commands back to back.
    $display("[TB] rejected commands");
    applyStimulus(8'h07, 1'b1);
    step();
    applyStimulus(8'hC0, 1'b1);
    step();
    checkOutput("erro07", 64'(erro_cmd), 64'd1);
    applyStimulus(8'h00, 1'b0);
    step();
    checkOutput("erroC0", 64'(erro_cmd), 64'd1);
    step();
    checkOutput("erroFim", 64'(erro_cmd), 64'd0);
    checkOutput("erroSemGate", 64'(ocupado), 64'd0);

    // External open reverses a closing gate 3; close ignored while held.
    $display("[TB] external open gate 3");
    sendCmd(8'h03);
    repeat (27) step();
    abrir_externo[3] = 1'b1;
    step();
    checkOutput("ext3Aberta", 64'(aberta[3]), 64'd0);
    checkOutput("ext3Ocupado", 64'(ocupado[3]), 64'd1);
    n = 0;
    while (aberta[3] !== 1'b1 && n < 40) begin step(); n++; end
    checkOutput("ext3Reabre", 64'(n), 64'd4);
    sendCmd(8'h43);
    repeat (15) step();
    checkOutput("ext3IgnoraFechar", 64'(aberta[3]), 64'd1);
    abrir_externo[3] = 1'b0;
    n = 0;
    while (ocupado[3] === 1'b1 && n < 60) begin step(); n++; end
    checkOutput("ext3Fecha", 64'(ocupado[3]), 64'd0);

    // Open command while gate 0 is closing at position 2.
    $display("[TB] open during closing gate 0");
    sendCmd(8'h00);
    repeat (27) step();
    sendCmd(8'h00);
    n = 0;
    while (aberta[0] !== 1'b1 && ocupado[0] === 1'b1 && n < 40) begin step(); n++; end
    checkOutput("reabrirCiclos", 64'(n), REABRIR ? 64'd4 : 64'd5);
    checkOutput("reabrirAberta", 64'(aberta[0]), 64'(REABRIR));
    n = 0;
    while (ocupado[0] === 1'b1 && n < 60) begin step(); n++; end
    checkOutput("reabrirFecha", 64'(ocupado[0]), 64'd0);

    // Random commands and external requests against the model.
    $display("[TB] random phase");
    for (int c = 0; c < 400; c++) begin
      applyStimulus(8'($urandom), ($urandom_range(2) == 0));
      if ($urandom_range(15) == 0) begin
        idx = int'($urandom_range(N - 1));
        abrir_externo[idx] = ~abrir_externo[idx];
      end
      step();
    end
    applyStimulus(8'h00, 1'b0);
    abrir_externo = '0;

    // Reset in the middle of a ramp.
    $display("[TB] reset mid ramp");
    sendCmd(8'h01);
    repeat (5) step();
    reset = 1'b1;
    step();
    checkOutput("midResetOcupado", 64'(ocupado), 64'd0);
    checkOutput("midResetAberta", 64'(aberta), 64'd0);
    checkOutput("midResetPwm", 64'(pwm), 64'd0);
    reset = 1'b0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
